adler32_par: RTL and testbench



---
 rtl/adler32_par_if.sv | 38 +++
 rtl/adler32_par.sv | 120 ++++++++++++
 tb/tb_adler32_par.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adler32_par_if.sv
// Beat-level bus for adler32_par: the input beat and start/last controls, plus the checksum result.
// Defining ADLER32_PAR_CHK_EN adds the expected-checksum input and the error flag.
interface adler32_par_if #(
  parameter int BYTE_NUM = 4
);
  localparam int NUM_WD = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;

  logic                  start_i;
  logic                  val_i;
  logic [8*BYTE_NUM-1:0] dat_i;
  logic [NUM_WD-1:0]     num_i;
  logic                  lst_i;
  logic                  done_o;
  logic                  val_o;
  logic [31:0]           dat_o;
`ifdef ADLER32_PAR_CHK_EN
  logic [31:0]           chk_dat_i;
  logic                  err_o;

  modport master (
    output start_i, val_i, dat_i, num_i, lst_i, chk_dat_i,
    input  done_o, val_o, dat_o, err_o
  );
  modport slave (
    input  start_i, val_i, dat_i, num_i, lst_i, chk_dat_i,
    output done_o, val_o, dat_o, err_o
  );
`else
  modport master (
    output start_i, val_i, dat_i, num_i, lst_i,
    input  done_o, val_o, dat_o
  );
  modport slave (
    input  start_i, val_i, dat_i, num_i, lst_i,
    output done_o, val_o, dat_o
  );
`endif
endinterface

// File: rtl/adler32_par.sv
// Adler-32 engine taking BYTE_NUM bytes per beat (MSB first) with a per-beat byte count.
// Defining ADLER32_PAR_CHK_EN adds a checksum comparator driving err_o.
module adler32_par #(
  parameter int BYTE_NUM = 4
) (
  input  logic          clk,
  input  logic          rstn,
  adler32_par_if.slave  bus
);

  localparam int NUM_WD = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
  localparam int SW     = 16 + NUM_WD + 10;
  localparam int MOD    = 65521;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [15:0]     r_s1;
  logic [15:0]     r_s2;
  logic [31:0]     r_dat;
  logic            r_done;
  logic            w_accept;
  logic            w_last;
  logic [3:0]      w_numc;
  logic [3:0]      w_n;
  logic [SW-1:0]   w_bsum;
  logic [SW-1:0]   w_wsum;
  logic [SW-1:0]   w_s1sum;
  logic [SW-1:0]   w_s2sum;
  logic [SW-1:0]   w_f1;
  logic [SW-1:0]   w_f2;
  logic [15:0]     w_s1n;
  logic [15:0]     w_s2n;

  assign w_accept = (r_state == S_RUN) && bus.val_i && !bus.start_i;
  assign w_last   = w_accept && bus.lst_i;

  always_comb begin
    w_nextState = r_state;
    if (bus.start_i) begin
      w_nextState = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (bus.val_i && bus.lst_i) w_nextState = S_DONE;
        S_DONE:  w_nextState = S_IDLE;
        default: w_nextState = r_state;
      endcase
    end
  end

  // Byte lane i carries weight n-i in s2; lanes past the clamped count are dropped.
  always_comb begin
    w_numc = {{(4-NUM_WD){1'b0}}, bus.num_i};
    if (w_numc > 4'(BYTE_NUM - 1)) w_numc = 4'(BYTE_NUM - 1);
    w_n    = w_numc + 4'd1;
    w_bsum = '0;
    w_wsum = '0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      if (4'(i) <= w_numc) begin
        w_bsum = w_bsum + SW'(bus.dat_i[8*(BYTE_NUM-i)-1 -: 8]);
        w_wsum = w_wsum + SW'(bus.dat_i[8*(BYTE_NUM-i)-1 -: 8]) * SW'(w_n - 4'(i));
      end
    end
    w_s1sum = SW'(r_s1) + w_bsum;
    w_s1n   = (w_s1sum >= SW'(MOD)) ? 16'(w_s1sum - SW'(MOD)) : w_s1sum[15:0];
    w_s2sum = SW'(r_s2) + SW'(r_s1) * SW'(w_n) + w_wsum;
    // 2^16 = 15 mod 65521: two folds bring any SW-bit value below 2^17.
    w_f1    = SW'(w_s2sum[SW-1:16]) * SW'(15) + SW'(w_s2sum[15:0]);
    w_f2    = SW'(w_f1[SW-1:16]) * SW'(15) + SW'(w_f1[15:0]);
    w_s2n   = (w_f2 >= SW'(MOD)) ? 16'(w_f2 - SW'(MOD)) : w_f2[15:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_s1    <= 16'd1;
      r_s2    <= 16'd0;
      r_dat   <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= w_last;
      if (bus.start_i) begin
        r_s1  <= 16'd1;
        r_s2  <= 16'd0;
        r_dat <= 32'd0;
      end else if (w_accept) begin
        r_s1 <= w_s1n;
        r_s2 <= w_s2n;
        if (bus.lst_i) r_dat <= {w_s2n, w_s1n};
      end
    end
  end

  assign bus.done_o = r_done;
  assign bus.val_o  = r_done;
  assign bus.dat_o  = r_dat;

`ifdef ADLER32_PAR_CHK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (bus.start_i) begin
      r_err <= 1'b0;
    end else if (w_last) begin
      r_err <= ({w_s2n, w_s1n} != bus.chk_dat_i);
    end
  end

  assign bus.err_o = r_err;
`endif

endmodule

// File: tb/tb_adler32_par.sv
// Bench for adler32_par: 1-, 4- and 8-lane instances share one stimulus driver,
// results are compared with a byte-serial Adler-32 model.
module tb_adler32_par;

  logic        clk;
  logic        rstn;
  logic        tbStart;
  logic        tbVal;
  logic        tbLst;
  logic [63:0] tbDat;
  logic [2:0]  tbNum;
  int          sel;
  int          checkCount;
  int          passCount;
  logic [7:0]  streamQ[$];
  logic [31:0] result;
  logic        sawDone;

  adler32_par_if #(.BYTE_NUM(1)) if1();
  adler32_par_if #(.BYTE_NUM(4)) if4();
  adler32_par_if #(.BYTE_NUM(8)) if8();

  adler32_par #(.BYTE_NUM(1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
  adler32_par #(.BYTE_NUM(4)) dut4 (.clk(clk), .rstn(rstn), .bus(if4));
  adler32_par #(.BYTE_NUM(8)) dut8 (.clk(clk), .rstn(rstn), .bus(if8));

  assign if1.start_i = tbStart && (sel == 1);
  assign if4.start_i = tbStart && (sel == 4);
  assign if8.start_i = tbStart && (sel == 8);
  assign if1.val_i   = tbVal && (sel == 1);
  assign if4.val_i   = tbVal && (sel == 4);
  assign if8.val_i   = tbVal && (sel == 8);
  assign if1.lst_i   = tbLst;
  assign if4.lst_i   = tbLst;
  assign if8.lst_i   = tbLst;
  assign if1.dat_i   = tbDat[63:56];
  assign if4.dat_i   = tbDat[63:32];
  assign if8.dat_i   = tbDat;
  assign if1.num_i   = tbNum[0:0];
  assign if4.num_i   = tbNum[1:0];
  assign if8.num_i   = tbNum;

  logic        obsDone;
  logic        obsVal;
  logic [31:0] obsDat;
  assign obsDone = (sel == 1) ? if1.done_o : (sel == 8) ? if8.done_o : if4.done_o;
  assign obsVal  = (sel == 1) ? if1.val_o  : (sel == 8) ? if8.val_o  : if4.val_o;
  assign obsDat  = (sel == 1) ? if1.dat_o  : (sel == 8) ? if8.dat_o  : if4.dat_o;

`ifdef ADLER32_PAR_CHK_EN
  logic [31:0] tbChk;
  logic        obsErr;
  assign if1.chk_dat_i = tbChk;
  assign if4.chk_dat_i = tbChk;
  assign if8.chk_dat_i = tbChk;
  assign obsErr = (sel == 1) ? if1.err_o : (sel == 8) ? if8.err_o : if4.err_o;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount = checkCount + 1;
    if (obs === exp) passCount = passCount + 1;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Plain byte-serial Adler-32 over the whole stream.
  function automatic logic [31:0] adlerRef();
    int a;
    int b;
    a = 1;
    b = 0;
    foreach (streamQ[k]) begin
      a = (a + int'(streamQ[k])) % 65521;
      b = (b + a) % 65521;
    end
    return {16'(b), 16'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int lanes, input bit fullBeats, input bit gaps,
                               input string tag, output logic [31:0] res);
    int idx;
    int n;
    bit early;
    sel     = lanes;
    tbStart = 1'b1;
    tbVal   = 1'b0;
    tbLst   = 1'b0;
    tick();
    tbStart = 1'b0;
    checkOutput({tag, "/clr"}, obsDat, 32'h0);
    idx   = 0;
    early = 1'b0;
    while (idx < streamQ.size()) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        tbVal = 1'b0;
        tbLst = 1'($urandom_range(0, 1));
        tbDat = {$urandom, $urandom};
      end else begin
        n = fullBeats ? lanes : int'($urandom_range(1, lanes));
        if (n > streamQ.size() - idx) n = streamQ.size() - idx;
        tbDat = {$urandom, $urandom};
        for (int k = 0; k < n; k++) tbDat[63-8*k -: 8] = streamQ[idx+k];
        tbNum = 3'(n - 1);
        if (lanes == 1) tbNum[0] = 1'($urandom_range(0, 1));
        tbLst = (idx + n == streamQ.size());
        tbVal = 1'b1;
        idx   = idx + n;
      end
      tick();
      if (idx < streamQ.size() && obsDone) early = 1'b1;
    end
    tbVal = 1'b0;
    tbLst = 1'b0;
    res   = obsDat;
    checkOutput({tag, "/early"}, 32'(early), 32'h0);
    checkOutput({tag, "/doneVal"}, {30'b0, obsDone, obsVal}, 32'h3);
    checkOutput({tag, "/dat"}, obsDat, adlerRef());
    tick();
    checkOutput({tag, "/holdDone"}, {30'b0, obsDone, obsVal}, 32'h0);
    checkOutput({tag, "/holdDat"}, obsDat, adlerRef());
  endtask

  initial begin
    int lanesTab[3];
    lanesTab   = '{1, 4, 8};
    checkCount = 0;
    passCount  = 0;
    rstn       = 1'b0;
    tbStart    = 1'b0;
    tbVal      = 1'b0;
    tbLst      = 1'b0;
    tbDat      = '0;
    tbNum      = '0;
    sel        = 4;
`ifdef ADLER32_PAR_CHK_EN
    tbChk      = '0;
`endif
    $display("[TB] adler32_par bench start");
    repeat (3) tick();
    foreach (lanesTab[j]) begin
      sel = lanesTab[j];
      #0;
      checkOutput($sformatf("reset%0d", sel), {obsDat[31:2], obsDone, obsVal}, 32'h0);
    end
    rstn = 1'b1;
    tick();

    streamQ = '{8'h61, 8'h62, 8'h63};
    applyStimulus(4, 1'b1, 1'b0, "abc", result);
    checkOutput("abcConst", result, 32'h024D0127);

    foreach (lanesTab[j]) begin
      streamQ = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
      applyStimulus(lanesTab[j], 1'b1, 1'b0, $sformatf("wiki%0d", lanesTab[j]), result);
      checkOutput($sformatf("wikiConst%0d", lanesTab[j]), result, 32'h11E60398);
    end

    streamQ = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    applyStimulus(4, 1'b1, 1'b0, "ff1", result);
    checkOutput("ff1Const", result, 32'h09FA03FD);

    streamQ.delete();
    for (int k = 0; k < 65536; k++) streamQ.push_back(8'hFF);
    applyStimulus(4, 1'b1, 1'b0, "ffBig", result);

    // Restart: a beat presented together with start_i must be dropped.
    sel     = 4;
    tbStart = 1'b1;
    tick();
    tbStart = 1'b0;
    repeat (2) begin
      tbVal = 1'b1;
      tbLst = 1'b0;
      tbDat = {$urandom, $urandom};
      tbNum = 3'd3;
      tick();
    end
    tbStart = 1'b1;
    tbLst   = 1'b1;
    tbDat   = {$urandom, $urandom};
    tick();
    tbStart = 1'b0;
    checkOutput("restartNoDone", {31'b0, obsDone}, 32'h0);
    tbDat = {32'h61626300, $urandom};
    tbNum = 3'd2;
    tick();
    tbVal = 1'b0;
    tbLst = 1'b0;
    checkOutput("restartDone", {31'b0, obsDone}, 32'h1);
    checkOutput("restartDat", obsDat, 32'h024D0127);

    sawDone = 1'b0;
    tick();
    repeat (5) begin
      tbVal = 1'b1;
      tbLst = 1'b1;
      tbDat = {$urandom, $urandom};
      tbNum = 3'($urandom_range(0, 3));
      tick();
      if (obsDone) sawDone = 1'b1;
    end
    tbVal = 1'b0;
    tbLst = 1'b0;
    checkOutput("idleNoDone", {31'b0, sawDone}, 32'h0);
    checkOutput("idleDat", obsDat, 32'h024D0127);

    for (int r = 0; r < 9; r++) begin
      streamQ.delete();
      repeat ($urandom_range(1, 40)) streamQ.push_back(8'($urandom));
      applyStimulus(lanesTab[r % 3], 1'b0, 1'b1, $sformatf("rand%0d", r), result);
    end

    // Asynchronous reset in the middle of an 8-lane stream.
    sel     = 8;
    tbStart = 1'b1;
    tick();
    tbStart = 1'b0;
    repeat (3) begin
      tbVal = 1'b1;
      tbLst = 1'b0;
      tbDat = {$urandom, $urandom};
      tbNum = 3'd7;
      tick();
    end
    tbLst = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checkOutput("midRstDat", obsDat, 32'h0);
    checkOutput("midRstDone", {30'b0, obsDone, obsVal}, 32'h0);
    tick();
    rstn    = 1'b1;
    sawDone = 1'b0;
    repeat (4) begin
      tick();
      if (obsDone) sawDone = 1'b1;
    end
    tbVal = 1'b0;
    tbLst = 1'b0;
    checkOutput("midRstNoDone", {31'b0, sawDone}, 32'h0);
    checkOutput("midRstDatHeld", obsDat, 32'h0);

`ifdef ADLER32_PAR_CHK_EN
    streamQ = '{8'h61, 8'h62, 8'h63};
    tbChk   = 32'h024D0127;
    applyStimulus(4, 1'b1, 1'b0, "chkOk", result);
    checkOutput("chkOkErr", {31'b0, obsErr}, 32'h0);
    tbChk   = 32'h024D0128;
    applyStimulus(4, 1'b1, 1'b0, "chkBad", result);
    checkOutput("chkBadErr", {31'b0, obsErr}, 32'h1);
    repeat (3) tick();
    checkOutput("chkBadHold", {31'b0, obsErr}, 32'h1);
    tbStart = 1'b1;
    tick();
    tbStart = 1'b0;
    checkOutput("chkClear", {31'b0, obsErr}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
